counter_mod_k_down_timer: RTL

Programmable down-counting timer, the counting-direction counterpart of the team's modulo-k up-counter. After a start request it loads a period k and counts k-1 … 0, emitting a one-cycle terminal tick when the count expires. It then either stops in a done state or, when reload is compiled in, reloads and repeats. It sits beside the up-counter in the timing/sequencing layer and drives timeouts, delays and periodic strobes.

---
 rtl/counter_mod_k_down_timer.sv | 97 +++++++++
 1 files changed

// File: rtl/counter_mod_k_down_timer.sv
// ============================================================================
// Module   : counter_mod_k_down_timer
// Brief    : Programmable down-counting timer. It loads period k on start,
//            counts k-1..0 and emits a one-cycle terminal tick. Define
//            COUNTER_MOD_K_DOWN_RELOAD_EN for auto-reload instead of one-shot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module counter_mod_k_down_timer #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic [N-1:0] i_k,
    input  logic         i_start,
    input  logic         i_enable,
    input  logic         i_abort,
    output logic [N-1:0] o_count,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_tick,
    output logic         o_err
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;
    localparam logic [N-1:0] c_ZERO  = '0;
    localparam logic [N-1:0] c_ONE   = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   r_state;
    logic [N-1:0] r_count;
    logic [N-1:0] r_k_lat;
    logic         r_tick;
    logic         r_err;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= c_ST_IDLE;
            r_count <= c_ZERO;
            r_k_lat <= c_ZERO;
            r_tick  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // Pulse outputs are only ever set for the single cycle that asks for them.
            r_tick <= 1'b0;
            r_err  <= 1'b0;
            if (i_abort) begin
                r_state <= c_ST_IDLE;
                r_count <= c_ZERO;
            end else begin
                case (r_state)
                    c_ST_IDLE, c_ST_DONE: begin
                        if (i_start) begin
                            if (i_k != c_ZERO) begin
                                r_k_lat <= i_k;
                                r_count <= i_k - c_ONE;
                                r_state <= c_ST_RUN;
                            end else begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                    c_ST_RUN: begin
                        if (i_enable) begin
                            if (r_count != c_ZERO) begin
                                r_count <= r_count - c_ONE;
                            end else begin
                                r_tick <= 1'b1;
`ifdef COUNTER_MOD_K_DOWN_RELOAD_EN
                                r_count <= r_k_lat - c_ONE;
`else
                                r_count <= c_ZERO;
                                r_state <= c_ST_DONE;
`endif
                            end
                        end
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_count <= c_ZERO;
                    end
                endcase
            end
        end
    end

    assign o_count = r_count;
    assign o_busy  = (r_state == c_ST_RUN);
    assign o_done  = (r_state == c_ST_DONE);
    assign o_tick  = r_tick;
    assign o_err   = r_err;

endmodule

`default_nettype wire
